// File: rtl/sw_in_ctrl.sv
// -----------------------------------------------------------------------------
// sw_in_ctrl
//
// Memory-mapped switch input controller. Each raw switch is brought into the
// clk domain through a two-flop synchronizer and then debounced: a new level
// is accepted only after it has been seen for DB_CYCLES consecutive cycles.
// Every accepted level change is recorded in sticky write-1-to-clear RISE and
// FALL registers, and a maskable level interrupt is raised while any enabled
// flag is pending.
//
// Register map (addr[3:2]):
//   0 STATE   debounced levels, read-only
//   1 RISE    sticky rising-edge flags, W1C
//   2 FALL    sticky falling-edge flags, W1C
//   3 IRQ_EN  interrupt mask, read/write
//
// Ports:
//   clk    clock (only clock)
//   rst    synchronous active-high reset
//   sw_i   raw asynchronous switch levels [NSW-1:0]
//   we     bus write strobe
//   addr   byte address, addr[3:2] decoded
//   wdata  bus write data
//   rdata  bus read data, combinational from addr, bits above NSW read 0
//   irq_o  level interrupt = |((RISE | FALL) & IRQ_EN)
// -----------------------------------------------------------------------------
module sw_in_ctrl #(
  parameter int NSW       = 16,
  parameter int DB_CYCLES = 20000,
  parameter int CNT_W     = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NSW-1:0] sw_i,
  input  logic           we,
  input  logic [3:0]     addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic           irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] A_STATE = 2'd0;
  localparam logic [1:0] A_RISE  = 2'd1;
  localparam logic [1:0] A_FALL  = 2'd2;
  localparam logic [1:0] A_EN    = 2'd3;

  logic [NSW-1:0]   s1_q, s2_q;
  logic [NSW-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NSW];
  logic [CNT_W-1:0] cnt_d [NSW];
  logic [NSW-1:0]   rise_q, rise_d;
  logic [NSW-1:0]   fall_q, fall_d;
  logic [NSW-1:0]   en_q, en_d;

  logic [NSW-1:0]   rise_set, fall_set;
  logic [NSW-1:0]   rise_clr, fall_clr;
  logic             wr_rise, wr_fall, wr_en;

  // Byte-lane bits and the upper data bits are not used by this block.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:NSW]};

  assign wr_rise = we && (addr[3:2] == A_RISE);
  assign wr_fall = we && (addr[3:2] == A_FALL);
  assign wr_en   = we && (addr[3:2] == A_EN);

  // Debounce: the counter only runs while the synchronized level disagrees
  // with the accepted level, so any return to the stable value restarts it.
  // The terminal compare also keeps the counter from ever wrapping.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NSW; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edge flags: a set in the same cycle as a W1C clear wins, so the OR of the
  // set term is applied after masking with the clear.
  always_comb begin
    rise_set = stable_d & ~stable_q;
    fall_set = ~stable_d & stable_q;
    rise_clr = wr_rise ? wdata[NSW-1:0] : '0;
    fall_clr = wr_fall ? wdata[NSW-1:0] : '0;
    rise_d   = (rise_q & ~rise_clr) | rise_set;
    fall_d   = (fall_q & ~fall_clr) | fall_set;
    en_d     = wr_en ? wdata[NSW-1:0] : en_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      en_q     <= '0;
      for (int i = 0; i < NSW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      en_q     <= en_d;
      for (int i = 0; i < NSW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      A_STATE: rdata[NSW-1:0] = stable_q;
      A_RISE:  rdata[NSW-1:0] = rise_q;
      A_FALL:  rdata[NSW-1:0] = fall_q;
      default: rdata[NSW-1:0] = en_q;
    endcase
  end

  assign irq_o = |((rise_q | fall_q) & en_q);

endmodule

// File: tb/tb_sw_in_ctrl.sv
module tb_sw_in_ctrl;

  localparam int NSW = 16;
  localparam int DB  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_i;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq_o;

  int checks   = 0;
  int failures = 0;

  sw_in_ctrl #(.NSW(NSW), .DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_i  (sw_i),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last DB synchronized
  // samples all disagree with the currently accepted level.
  logic [15:0] m_s1, m_stable, m_rise, m_fall, m_en;
  logic [15:0] m_hist [DB];

  always @(posedge clk) begin : model
    logic [15:0] nst, rs, fs, clr_r, clr_f;
    logic        all_diff;
    if (rst) begin
      m_s1 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_en = '0;
      for (int j = 0; j < DB; j++) m_hist[j] = '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
          if (m_hist[j][i] == m_stable[i]) all_diff = 1'b0;
        nst[i] = all_diff ? ~m_stable[i] : m_stable[i];
      end
      rs    = nst & ~m_stable;
      fs    = ~nst & m_stable;
      clr_r = (we && addr[3:2] == 2'd1) ? wdata[15:0] : 16'h0;
      clr_f = (we && addr[3:2] == 2'd2) ? wdata[15:0] : 16'h0;
      m_rise = (m_rise & ~clr_r) | rs;
      m_fall = (m_fall & ~clr_f) | fs;
      if (we && addr[3:2] == 2'd3) m_en = wdata[15:0];
      for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s1;
      m_s1      = sw_i;
      m_stable  = nst;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {16'h0, m_stable};
      2'd1:    return {16'h0, m_rise};
      2'd2:    return {16'h0, m_fall};
      default: return {16'h0, m_en};
    endcase
  endfunction

  // Stimulus helpers (inputs change on the falling edge).
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; wdata = '0;
  endtask

  task automatic set_addr(input logic [3:0] a);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] a;
    rst = 1'b1; sw_i = '0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      set_addr(a);
      checks++;
      if (rdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_rdata addr=%h got=%h exp=%h", a, rdata, 32'h0);
      end
    end
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", irq_o);
    end
  endtask

  task automatic test_rise();
    @(negedge clk);
    sw_i = 16'h0001;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      set_addr(4'h0);
      if (e == 5) begin
        checks++;
        if (rdata !== 32'h0) begin
          failures++;
          $display("FAIL rise_latency_early got=%h exp=%h", rdata, 32'h0);
        end
      end
      if (e == 6) begin
        checks++;
        if (rdata !== 32'h1) begin
          failures++;
          $display("FAIL rise_latency_state got=%h exp=%h", rdata, 32'h1);
        end
      end
    end
    set_addr(4'h4);
    checks++;
    if (rdata !== 32'h1) begin
      failures++;
      $display("FAIL rise_flag got=%h exp=%h", rdata, 32'h1);
    end
    set_addr(4'h8);
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL rise_fall_clear got=%h exp=%h", rdata, 32'h0);
    end
    bus_write(4'h4, 32'h1);
    set_addr(4'h4);
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL rise_w1c got=%h exp=%h", rdata, 32'h0);
    end
  endtask

  task automatic test_glitch();
    sw_i = 16'h0009;
    repeat (3) @(negedge clk);
    sw_i = 16'h0001;
    repeat (10) @(negedge clk);
    set_addr(4'h0);
    checks++;
    if (rdata !== 32'h1) begin
      failures++;
      $display("FAIL glitch_state got=%h exp=%h", rdata, 32'h1);
    end
    set_addr(4'h4);
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL glitch_rise got=%h exp=%h", rdata, 32'h0);
    end
    set_addr(4'h8);
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL glitch_fall got=%h exp=%h", rdata, 32'h0);
    end
    sw_i = 16'h0009;
    repeat (8) @(negedge clk);
    set_addr(4'h0);
    checks++;
    if (rdata !== 32'h9) begin
      failures++;
      $display("FAIL glitch_hold_state got=%h exp=%h", rdata, 32'h9);
    end
    set_addr(4'h4);
    checks++;
    if (rdata !== 32'h8) begin
      failures++;
      $display("FAIL glitch_hold_rise got=%h exp=%h", rdata, 32'h8);
    end
  endtask

  task automatic test_irq();
    bus_write(4'h4, 32'hFFFF);
    bus_write(4'h8, 32'hFFFF);
    bus_write(4'hC, 32'hFFFF_0002);
    set_addr(4'hC);
    checks++;
    if (rdata !== 32'h2) begin
      failures++;
      $display("FAIL irq_en_readback got=%h exp=%h", rdata, 32'h2);
    end
    sw_i = 16'h000B;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      #1;
      if (e == 5) begin
        checks++;
        if (irq_o !== 1'b0) begin
          failures++;
          $display("FAIL irq_early got=%b exp=0", irq_o);
        end
      end
      if (e == 6) begin
        checks++;
        if (irq_o !== 1'b1) begin
          failures++;
          $display("FAIL irq_assert got=%b exp=1", irq_o);
        end
      end
    end
    bus_write(4'h4, 32'h2);
    #1;
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL irq_w1c got=%b exp=0", irq_o);
    end
    sw_i = 16'h000A;
    repeat (8) @(negedge clk);
    sw_i = 16'h000B;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL irq_masked got=%b exp=0", irq_o);
    end
    set_addr(4'h4);
    checks++;
    if (rdata !== 32'h1) begin
      failures++;
      $display("FAIL irq_masked_rise got=%h exp=%h", rdata, 32'h1);
    end
  endtask

  task automatic test_set_wins();
    sw_i = 16'h000F;
    repeat (8) @(negedge clk);
    bus_write(4'h8, 32'hFFFF);
    set_addr(4'h8);
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL setwins_pre got=%h exp=%h", rdata, 32'h0);
    end
    sw_i = 16'h000B;
    repeat (5) @(negedge clk);
    we = 1'b1; addr = 4'h8; wdata = 32'h4;
    @(negedge clk);
    we = 1'b0; wdata = '0;
    set_addr(4'h8);
    checks++;
    if (rdata !== 32'h4) begin
      failures++;
      $display("FAIL setwins_fall got=%h exp=%h", rdata, 32'h4);
    end
    set_addr(4'h0);
    checks++;
    if (rdata !== 32'hB) begin
      failures++;
      $display("FAIL setwins_state got=%h exp=%h", rdata, 32'hB);
    end
    bus_write(4'h8, 32'h4);
    set_addr(4'h8);
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL setwins_clear got=%h exp=%h", rdata, 32'h0);
    end
  endtask

  task automatic test_rst_mid();
    logic [3:0] a;
    sw_i = 16'h0000;
    repeat (8) @(negedge clk);
    bus_write(4'h4, 32'hFFFF);
    bus_write(4'h8, 32'hFFFF);
    sw_i = 16'h00FF;
    repeat (8) @(negedge clk);
    set_addr(4'h4);
    checks++;
    if (rdata !== 32'hFF) begin
      failures++;
      $display("FAIL rstmid_rise got=%h exp=%h", rdata, 32'hFF);
    end
    bus_write(4'hC, 32'hFFFF);
    #1;
    checks++;
    if (irq_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_irq_pre got=%b exp=1", irq_o);
    end
    sw_i = 16'hFF00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      set_addr(a);
      checks++;
      if (rdata !== 32'h0) begin
        failures++;
        $display("FAIL rstmid_rdata addr=%h got=%h exp=%h", a, rdata, 32'h0);
      end
    end
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_irq got=%b exp=0", irq_o);
    end
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      set_addr(4'h0);
      if (e == 5) begin
        checks++;
        if (rdata !== 32'h0) begin
          failures++;
          $display("FAIL rstmid_early got=%h exp=%h", rdata, 32'h0);
        end
      end
      if (e == 6) begin
        checks++;
        if (rdata !== 32'hFF00) begin
          failures++;
          $display("FAIL rstmid_redebounce got=%h exp=%h", rdata, 32'hFF00);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold;
    logic [31:0] exp;
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (hold == 0) begin
        sw_i = sw_i ^ (16'($urandom) & 16'($urandom));
        hold = $urandom_range(1, 7);
      end else begin
        hold--;
      end
      rst   = ($urandom_range(0, 299) == 0);
      we    = ($urandom_range(0, 5) == 0);
      addr  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      #1;
      exp = exp_rd(addr);
      checks++;
      if (rdata !== exp) begin
        failures++;
        $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, addr, rdata, exp);
      end
      checks++;
      if (irq_o !== |((m_rise | m_fall) & m_en)) begin
        failures++;
        $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq_o, |((m_rise | m_fall) & m_en));
      end
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_irq();
    test_set_wins();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
